// File: rtl/demux2_queue.sv
// demux2_queue: one val/rdy stream steered per message to two lanes.
// Each lane buffers up to two messages in a small circular FIFO.
module demux2_queue #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  input  logic               in_sel,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out1_msg
);

  logic               enq  [2];
  logic               ordy [2];
  logic               full [2];
  logic               val  [2];
  logic [p_nbits-1:0] head [2];

  // in_rdy only looks at registered lane state, never at outN_rdy
  assign in_rdy  = in_sel ? ~full[1] : ~full[0];
  assign enq[0]  = in_val & in_rdy & ~in_sel;
  assign enq[1]  = in_val & in_rdy & in_sel;
  assign ordy[0] = out0_rdy;
  assign ordy[1] = out1_rdy;

  assign out0_val = val[0];
  assign out0_msg = head[0];
  assign out1_val = val[1];
  assign out1_msg = head[1];

  for (genvar n = 0; n < 2; n++) begin : g_lane
    logic [p_nbits-1:0] mem [2];
    logic               wp;
    logic               rp;
    logic [1:0]         cnt;
    logic               deq;

    assign deq     = val[n] & ordy[n];
    assign val[n]  = (cnt != 2'd0);
    assign full[n] = (cnt == 2'd2);
    assign head[n] = mem[rp];

    // write side: store the accepted message and advance wp
    always_ff @(posedge clk) begin
      if (rst) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wp     <= 1'b0;
      end else if (enq[n]) begin
        mem[wp] <= in_msg;
        wp      <= ~wp;
      end
    end

    // read side: advance rp on dequeue
    always_ff @(posedge clk) begin
      if (rst) begin
        rp <= 1'b0;
      end else if (deq) begin
        rp <= ~rp;
      end
    end

    // occupancy: enqueue and dequeue together leave it unchanged
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= 2'd0;
      end else begin
        unique case (1'b1)
          (enq[n] & ~deq): cnt <= cnt + 2'd1;
          (deq & ~enq[n]): cnt <= cnt - 2'd1;
          default:         cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux2_queue.sv
// tb_demux2_queue: scoreboard bench for demux2_queue.
// Per-lane queues plus an occupancy model predict val, rdy and data.
module tb_demux2_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        in_sel;
  logic        out0_val;
  logic        out0_rdy;
  logic [31:0] out0_msg;
  logic        out1_val;
  logic        out1_rdy;
  logic [31:0] out1_msg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  int          mcnt0 = 0;
  int          mcnt1 = 0;
  logic        acc;

  demux2_queue #(.p_nbits(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .in_sel   (in_sel),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: check at negedge against the model, then update it
  task automatic step();
    logic e_rdy;
    logic d0;
    logic d1;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      exp0.delete();
      exp1.delete();
      mcnt0 = 0;
      mcnt1 = 0;
    end else begin
      e_rdy = in_sel ? (mcnt1 != 2) : (mcnt0 != 2);
      d0 = (mcnt0 != 0) && out0_rdy;
      d1 = (mcnt1 != 0) && out1_rdy;
      chk("out0_val", {31'd0, out0_val}, {31'd0, mcnt0 != 0});
      chk("out1_val", {31'd0, out1_val}, {31'd0, mcnt1 != 0});
      if (in_val)
        chk("in_rdy", {31'd0, in_rdy}, {31'd0, e_rdy});
      if (d0 && exp0.size() != 0)
        chk("out0_msg", out0_msg, exp0.pop_front());
      if (d1 && exp1.size() != 0)
        chk("out1_msg", out1_msg, exp1.pop_front());
      acc = in_val && e_rdy;
      if (acc && in_sel)  exp1.push_back(in_msg);
      if (acc && !in_sel) exp0.push_back(in_msg);
      mcnt0 = mcnt0 + ((acc && !in_sel) ? 1 : 0) - (d0 ? 1 : 0);
      mcnt1 = mcnt1 + ((acc && in_sel) ? 1 : 0) - (d1 ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_v0"}, {31'd0, out0_val}, 32'd0);
    chk({tag, "_v1"}, {31'd0, out1_val}, 32'd0);
    chk({tag, "_m0"}, out0_msg, 32'd0);
    chk({tag, "_m1"}, out1_msg, 32'd0);
    in_sel = 1'b0;
    #1;
    chk({tag, "_rdy0"}, {31'd0, in_rdy}, 32'd1);
    in_sel = 1'b1;
    #1;
    chk({tag, "_rdy1"}, {31'd0, in_rdy}, 32'd1);
  endtask

  task automatic send(input logic sel, input logic [31:0] msg);
    in_val = 1'b1;
    in_sel = sel;
    in_msg = msg;
    step();
  endtask

  initial begin
    int tries;
    int sent;
    rst      = 1'b1;
    in_val   = 1'b0;
    in_msg   = '0;
    in_sel   = 1'b0;
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    idle_chk("reset");

    // alternating streaming, both consumers ready
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    for (int i = 0; i < 4; i++)
      send(i[0], 32'h11 * (i + 1));
    in_val = 1'b0;
    step();
    step();

    // lane 0 stalled: two accepted, third held, lane 1 still flows
    out0_rdy = 1'b0;
    send(1'b0, 32'hA0);
    send(1'b0, 32'hA1);
    in_val = 1'b1;
    in_sel = 1'b0;
    in_msg = 32'hA2;
    #1;
    chk("stall_rdy", {31'd0, in_rdy}, 32'd0);
    step();
    send(1'b1, 32'hB0);
    // full lane with dequeue in the same cycle: no enqueue
    out0_rdy = 1'b1;
    in_sel   = 1'b0;
    in_msg   = 32'hA2;
    #1;
    chk("full_rdy", {31'd0, in_rdy}, 32'd0);
    step();
    chk("full_acc", {31'd0, acc}, 32'd0);
    chk("refill_rdy", {31'd0, in_rdy}, 32'd1);
    step();
    chk("refill_acc", {31'd0, acc}, 32'd1);
    in_val = 1'b0;
    step();
    step();

    // count 1 on lane 1: enqueue and dequeue together
    out1_rdy = 1'b0;
    send(1'b1, 32'hC0);
    out1_rdy = 1'b1;
    send(1'b1, 32'hC1);
    chk("c1_cnt", mcnt1, 32'd1);
    chk("c1_msg", out1_msg, 32'hC1);
    chk("c1_val", {31'd0, out1_val}, 32'd1);

    // pointer wrap: 8 messages with a wobbling consumer
    sent  = 0;
    tries = 0;
    while (sent < 8 && tries < 100) begin
      out1_rdy = ($urandom_range(0, 3) != 0);
      send(1'b1, 32'hD0 + sent);
      if (acc) sent++;
      tries++;
    end
    chk("wrap_sent", sent, 32'd8);
    in_val   = 1'b0;
    out1_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // reset mid-stream with a concurrent message
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    send(1'b0, 32'hE0);
    send(1'b0, 32'hE1);
    send(1'b1, 32'hE2);
    rst    = 1'b1;
    in_val = 1'b1;
    in_sel = 1'b1;
    in_msg = 32'hEE;
    step();
    rst    = 1'b0;
    in_val = 1'b0;
    idle_chk("midrst");
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();

    chk("drain0", exp0.size(), 32'd0);
    chk("drain1", exp1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
